fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard detection logic and the decode stage. Drives a synchronous (1-cycle read latency) instruction memory, tracks the in-flight response, and loads the IF/ID register. It obeys the `PCWrite`/`IF_ID_Write` stall controls produced by hazard detection and the taken-branch/jump redirect from EX. A one-entry hold buffer keeps the response that arrives while decode is stalled, so no instruction is lost or re-fetched out of order.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_hold_buf.sv | 48 ++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP encoding, fetch FSM states and PC step.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INCR   = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer for an instruction response that arrives while decode is stalled.
// Owns the RUN/HOLD FSM; full is asserted in HOLD.
module fetch_hold_buf
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] cap_pc,
    input  logic [XLEN-1:0] cap_instr,
    output logic            full,
    output logic [XLEN-1:0] hold_pc,
    output logic [XLEN-1:0] hold_instr
);

    fetch_state_t state;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= RUN;
            hold_pc    <= '0;
            hold_instr <= XLEN'(NOP_INSTR);
        end else begin
            case (state)
                RUN: begin
                    if (capture) begin
                        hold_pc    <= cap_pc;
                        hold_instr <= cap_instr;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (drain) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign full = (state == HOLD);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register against a 1-cycle-latency instruction memory.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic            resp_valid;
    logic            advance;

    logic            hold_full;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic            hold_capture;
    logic            hold_drain;

    logic [XLEN-1:0] src_pc;
    logic [XLEN-1:0] src_instr;
    logic            src_valid;

    // Any disagreement between the two stall controls is treated as a stall.
    assign advance = PCWrite && IF_ID_Write;

    assign imem_en   = !reset;
    assign imem_addr = fetch_pc;

    always_comb begin
        src_pc    = resp_pc;
        src_instr = resp_valid ? imem_rdata : XLEN'(NOP_INSTR);
        src_valid = resp_valid;
        if (hold_full) begin
            src_pc    = hold_pc;
            src_instr = hold_instr;
            src_valid = 1'b1;
        end
    end

    assign hold_capture = !redirect && !advance && !hold_full && resp_valid;
    assign hold_drain   = !redirect && advance && hold_full;

    fetch_hold_buf #(
        .XLEN (XLEN)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .capture    (hold_capture),
        .drain      (hold_drain),
        .clear      (redirect),
        .cap_pc     (resp_pc),
        .cap_instr  (imem_rdata),
        .full       (hold_full),
        .hold_pc    (hold_pc),
        .hold_instr (hold_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= XLEN'(RESET_PC);
            resp_pc     <= XLEN'(RESET_PC);
            resp_valid  <= 1'b0;
            IF_ID_pc    <= '0;
            IF_ID_instr <= XLEN'(NOP_INSTR);
            IF_ID_valid <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            resp_valid  <= 1'b0;
            IF_ID_instr <= XLEN'(NOP_INSTR);
            IF_ID_valid <= 1'b0;
        end else begin
            // The response tracker follows the memory even while stalled.
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            if (advance) begin
                fetch_pc    <= fetch_pc + XLEN'(PC_INCR);
                IF_ID_pc    <= src_pc;
                IF_ID_instr <= src_instr;
                IF_ID_valid <= src_valid;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (redirect) begin
            if (perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end else if (!advance) begin
            if (perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
